// File: rtl/uart_tx_stream_if.sv
// Producer-to-transmitter word handshake for uart_tx_stream.
// A word moves on every clock edge where tx_valid and tx_ready are both high.
interface uart_tx_stream_if #(
  parameter int unsigned DATA_BITS = 8
) ();

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/uart_tx_stream.sv
// Buffered UART transmitter: valid/ready word input, small FIFO, LSB-first serial line.
// Optional parity bit is compiled in with `define UART_TX_PARITY_EN.
module uart_tx_stream #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                            tx_clk,
  input  logic                            tx_rst_n,
  uart_tx_stream_if.slave                 tx_bus,
  output logic                            tx_output,
  output logic                            tx_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

  localparam int unsigned DIV    = CLK_FREQ / BAUD_RATE;
  localparam int unsigned BAUD_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);

  localparam logic [BAUD_W-1:0] BaudLast = BAUD_W'(DIV - 1);
  localparam logic [3:0]        DataLast = 4'(DATA_BITS - 1);
  localparam logic [3:0]        StopLast = 4'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0]  CntFull  = CNT_W'(FIFO_DEPTH);

  // Reject illegal configurations at elaboration time.
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_stream: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_stream: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_stream: FIFO_DEPTH must be a power of two >= 2");
  end
  if (PARITY_ODD > 1) begin : g_bad_parity_odd
    $error("uart_tx_stream: PARITY_ODD must be 0 or 1");
  end
  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_stream: CLK_FREQ / BAUD_RATE must be at least 2");
  end

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_TX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [DATA_BITS-1:0] head;
  logic                 ready;
  logic                 push;
  logic                 pop;
  logic                 fifo_empty;

  // Serialiser state
  state_e               state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 baud_last;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  assign ready      = (count_q != CntFull);
  assign push       = tx_bus.tx_valid && ready;
  assign fifo_empty = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];
  assign baud_last  = (baud_q == BaudLast);

  assign tx_bus.tx_ready = ready;
  assign tx_output       = tx_q;
  assign tx_busy         = (state_q != StIdle);
  assign fifo_count      = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    if (state_q != StIdle) begin
      baud_d = baud_last ? '0 : baud_q + BAUD_W'(1);
    end

    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = head;
          tx_d    = 1'b0;
          state_d = StStart;
`ifdef UART_TX_PARITY_EN
          parity_d = (^head) ^ 1'(PARITY_ODD);
`endif
        end
      end

      StStart: begin
        if (baud_last) begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          bit_d   = '0;
          state_d = StData;
        end
      end

      StData: begin
        if (baud_last) begin
          if (bit_q == DataLast) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = StParity;
`else
            tx_d    = 1'b1;
            state_d = StStop;
`endif
          end else begin
            bit_d   = bit_q + 4'd1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (baud_last) begin
          tx_d    = 1'b1;
          state_d = StStop;
        end
      end
`endif

      StStop: begin
        if (baud_last) begin
          if (bit_q == StopLast) begin
            bit_d = '0;
            // Chain straight into the next start bit when more data is waiting.
            if (!fifo_empty) begin
              pop     = 1'b1;
              shift_d = head;
              tx_d    = 1'b0;
              state_d = StStart;
`ifdef UART_TX_PARITY_EN
              parity_d = (^head) ^ 1'(PARITY_ODD);
`endif
            end else begin
              tx_d    = 1'b1;
              state_d = StIdle;
            end
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end

      default: begin
        tx_d    = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge tx_clk or negedge tx_rst_n) begin
    if (!tx_rst_n) begin
      state_q  <= StIdle;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Storage needs no reset: count/pointers decide what is valid.
  always_ff @(posedge tx_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= tx_bus.tx_data;
    end
  end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Scoreboard bench for uart_tx_stream: randomized and directed words, line decoded by a monitor.
// Expected frames are built from the word, data width, parity rule and stop-bit count.
module tb_uart_tx_stream;

  localparam int unsigned CLK_FREQ  = 1_000_000;
  localparam int unsigned BAUD_RATE = 125_000;
  localparam int unsigned DIV       = CLK_FREQ / BAUD_RATE;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned PBITS = 1;
`else
  localparam int unsigned PBITS = 0;
`endif
  localparam int unsigned NB_A = 1 + 8 + PBITS + 1;
  localparam int unsigned NB_B = 1 + 7 + PBITS + 2;
  localparam int unsigned F_A  = NB_A * DIV;
  localparam bit          ODD_A = 1'b0;
  localparam bit          ODD_B = 1'b1;

  logic       tx_clk   = 1'b0;
  logic       tx_rst_n = 1'b0;
  logic       out_a, busy_a, out_b, busy_b;
  logic [2:0] cnt_a, cnt_b;

  always #5 tx_clk = ~tx_clk;

  uart_tx_stream_if #(.DATA_BITS(8)) bus_a ();
  uart_tx_stream_if #(.DATA_BITS(7)) bus_b ();

  uart_tx_stream #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .DATA_BITS(8), .STOP_BITS(1),
    .FIFO_DEPTH(4), .PARITY_ODD(0)
  ) u_dut_a (
    .tx_clk(tx_clk), .tx_rst_n(tx_rst_n), .tx_bus(bus_a),
    .tx_output(out_a), .tx_busy(busy_a), .fifo_count(cnt_a)
  );

  uart_tx_stream #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .DATA_BITS(7), .STOP_BITS(2),
    .FIFO_DEPTH(4), .PARITY_ODD(1)
  ) u_dut_b (
    .tx_clk(tx_clk), .tx_rst_n(tx_rst_n), .tx_bus(bus_b),
    .tx_output(out_b), .tx_busy(busy_b), .fifo_count(cnt_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int exp_q[$];
  int starts_a[$];
  int frames_a = 0;
  int last_start_a = -1;

  always @(posedge tx_clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Bit idx of the frame for word w: start, data LSB first, optional parity, stop bits.
  function automatic logic frame_bit(input int unsigned w, input int unsigned nbits,
                                     input bit odd, input int unsigned idx);
    int unsigned ones;
    if (idx == 0) return 1'b0;
    if (idx <= nbits) return ((w >> (idx - 1)) & 1) != 0;
    if (PBITS == 1 && idx == nbits + 1) begin
      ones = $countones(w & ((1 << nbits) - 1));
      return ((ones % 2) == 1) ^ odd;
    end
    return 1'b1;
  endfunction

  // Monitor: decode each frame on out_a and compare against the scoreboard head.
  initial begin : mon_a
    logic [NB_A-1:0] seen, expv;
    bit   aborted, stable;
    int   start, w;
    forever begin
      @(negedge tx_clk);
      if (tx_rst_n && out_a == 1'b0) begin
        start   = cyc;
        aborted = 1'b0;
        stable  = 1'b1;
        seen    = '0;
        for (int b = 0; b < NB_A && !aborted; b++) begin
          for (int c = 0; c < DIV && !aborted; c++) begin
            if (!(b == 0 && c == 0)) @(negedge tx_clk);
            if (!tx_rst_n) aborted = 1'b1;
            else if (c == 0) seen[b] = out_a;
            else if (out_a != seen[b]) stable = 1'b0;
          end
        end
        if (!aborted) begin
          frames_a++;
          last_start_a = start;
          starts_a.push_back(start);
          check("bit_width_stable", stable, 1);
          check("frame_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            w = exp_q.pop_front();
            for (int i = 0; i < NB_A; i++) expv[i] = frame_bit(w, 8, ODD_A, i);
            check("frame_bits", longint'(seen), longint'(expv));
          end
        end
      end
    end
  end

  // Called just after a negedge; returns one negedge later.
  task automatic push_a(input int w, output bit ok, output int acc);
    bus_a.tx_data  = w[7:0];
    bus_a.tx_valid = 1'b1;
    ok  = bus_a.tx_ready;
    acc = cyc + 1;
    if (ok) exp_q.push_back(w);
    @(negedge tx_clk);
    bus_a.tx_valid = 1'b0;
  endtask

  task automatic push_wait_a(input int w);
    bit ok;
    int acc;
    int tries = 0;
    do begin
      push_a(w, ok, acc);
      tries++;
    end while (!ok && tries < 2000);
    if (!ok) check("push_timeout", ok, 1);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge tx_clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    repeat (2) @(negedge tx_clk);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge tx_clk);
  endtask

  // Direct line check on instance B (7 data bits, 2 stop bits, odd parity).
  task automatic frame_b(input int w, input string name);
    int bad = 0;
    int unsigned idx;
    bus_b.tx_data  = w[6:0];
    bus_b.tx_valid = 1'b1;
    check({name, "_ready"}, bus_b.tx_ready, 1);
    @(negedge tx_clk);
    bus_b.tx_valid = 1'b0;
    for (int c = 0; c < NB_B * DIV; c++) begin
      @(negedge tx_clk);
      idx = c / DIV;
      if (out_b != frame_bit(w, 7, ODD_B, idx)) bad++;
    end
    check({name, "_line_errors"}, bad, 0);
    @(negedge tx_clk);
    check({name, "_busy_after"}, busy_b, 0);
    check({name, "_line_after"}, out_b, 1);
  endtask

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit ok;
    int acc, acc0, n_acc, s0, lows, frames0, w;
    bit oks[6];

    bus_a.tx_valid = 1'b0;
    bus_a.tx_data  = '0;
    bus_b.tx_valid = 1'b0;
    bus_b.tx_data  = '0;
    repeat (3) @(negedge tx_clk);
    check("rst_line", out_a, 1);
    check("rst_busy", busy_a, 0);
    check("rst_count", cnt_a, 0);
    check("rst_ready", bus_a.tx_ready, 1);
    check("rst_count_b", cnt_b, 0);
    tx_rst_n = 1'b1;
    repeat (2) @(negedge tx_clk);

    // Single 0x41: latency, frame length, idle afterwards.
    push_a(32'h41, ok, acc);
    check("single_accept", ok, 1);
    wait_cyc(acc + F_A);
    check("single_busy_last_stop", busy_a, 1);
    check("single_line_last_stop", out_a, 1);
    @(negedge tx_clk);
    check("single_busy_end", busy_a, 0);
    check("single_line_end", out_a, 1);
    drain(4 * F_A);
    check("single_latency", last_start_a, acc + 1);

    // Hold valid six cycles: five accepted, sixth refused, frames back to back.
    starts_a.delete();
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      push_a(int'($urandom_range(0, 255)), oks[i], acc);
      if (oks[i]) n_acc++;
    end
    check("hold_accepted", n_acc, 5);
    check("hold_sixth_refused", oks[5], 0);
    drain(8 * F_A);
    check("hold_frames", starts_a.size(), 5);
    for (int i = 1; i < starts_a.size(); i++)
      check("hold_gap", starts_a[i] - starts_a[i-1], F_A);
    check("hold_count_end", cnt_a, 0);

    // Push on the pop edge with two words waiting.
    push_a(32'hA5, ok, acc0);
    push_a(32'h3C, ok, acc);
    push_a(32'h0F, ok, acc);
    check("coll_count_before", cnt_a, 2);
    s0 = acc0 + 1;
    wait_cyc(s0 + F_A - 1);
    push_a(32'hC3, ok, acc);
    check("coll_accept", ok, 1);
    check("coll_count_after", cnt_a, 2);
    drain(8 * F_A);

    // Reset during D3 with two words queued.
    push_a(32'h96, ok, acc0);
    push_a(32'h11, ok, acc);
    push_a(32'h22, ok, acc);
    s0 = acc0 + 1;
    wait_cyc(s0 + 4 * DIV + 2);
    tx_rst_n = 1'b0;
    #1;
    check("midrst_line", out_a, 1);
    check("midrst_count", cnt_a, 0);
    check("midrst_ready", bus_a.tx_ready, 1);
    check("midrst_busy", busy_a, 0);
    exp_q.delete();
    @(negedge tx_clk);
    tx_rst_n = 1'b1;
    frames0 = frames_a;
    lows = 0;
    repeat (3 * F_A) begin
      @(negedge tx_clk);
      if (out_a == 1'b0) lows++;
    end
    check("post_rst_line_low", lows, 0);
    check("post_rst_frames", frames_a - frames0, 0);

    // Randomized traffic with random gaps.
    frames0 = frames_a;
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge tx_clk);
      w = int'($urandom_range(0, 255));
      push_wait_a(w);
    end
    drain(30 * F_A);
    check("rand_frames", frames_a - frames0, 20);
    check("rand_count_end", cnt_a, 0);
    check("rand_busy_end", busy_a, 0);

    // Narrow frame with two stop bits and odd parity option.
    frame_b(32'h7F, "b7f");
    frame_b(32'h41, "b41");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_stream.md
# uart_tx_stream

Parametrised UART transmitter, successor to the fixed-pattern 8N1 transmitter. It accepts bytes from on-chip logic through a valid/ready handshake and buffers them in a small FIFO. Each word is serialised LSB-first onto a single idle-high line, with a configurable data width, stop-bit count and optional parity. It sits between any command/debug producer and the board's UART TX pin.

## Interface
- CLK_FREQ, 50_000_000: tx_clk frequency in Hz.
- BAUD_RATE, 115_200: line rate in bit/s.
- DATA_BITS, 8: data bits per frame; legal range 5..9.
- STOP_BITS, 1: stop bits per frame; legal values 1 or 2.
- FIFO_DEPTH, 4: input buffer entries; power of two, 2 or more.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity. Used only with UART_TX_PARITY_EN.
- tx_clk  in  1  sole clock, rising-edge.
- tx_rst_n  in  1  asynchronous active-low reset.
- tx_data  in  DATA_BITS  word to send.
- tx_valid  in  1  producer offers tx_data.
- tx_ready  out  1  FIFO can accept a word.
- tx_output  out  1  serial line, idle high.
- tx_busy  out  1  a frame is on the line.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  words buffered, excluding the word being sent.

## Operation
- DIV = CLK_FREQ / BAUD_RATE, integer truncation; defaults give DIV = 434. Every bit lasts exactly DIV cycles; the baud counter runs 0..DIV-1.
- Accept: a word is written when tx_valid && tx_ready at a clock edge. tx_ready = (fifo_count != FIFO_DEPTH), combinational from registered count. While tx_ready is low, tx_valid is ignored; no word is lost or overwritten.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START when the FIFO is non-empty. The word is popped into the shift register at the same edge.
- START -> DATA after DIV cycles.
- DATA shifts out DATA_BITS bits, LSB first. It then goes to PARITY if the macro is defined, otherwise to STOP.
- PARITY lasts DIV cycles, then -> STOP.
- STOP lasts STOP_BITS×DIV cycles.
- At the final STOP cycle: go to START with a pop if the FIFO is non-empty (no idle gap), else go to IDLE.
- Simultaneous push and pop are legal. fifo_count is then unchanged and pointers wrap modulo FIFO_DEPTH.
- tx_busy = 1 in every state except IDLE.

## Timing
- tx_output is a registered output; no combinational path from inputs to the line.
- Reset values: tx_output = 1, tx_busy = 0, fifo_count = 0, tx_ready = 1, FSM in IDLE, baud counter 0.
- Reset asserted mid-frame: the line returns high immediately (asynchronous). The FIFO is flushed and the in-flight word is discarded.
- Latency: a word accepted at edge E into an empty FIFO while IDLE is popped at edge E+1. The start bit (tx_output = 0) is driven from edge E+1 for DIV cycles.
- Frame length: (1 + DATA_BITS + P + STOP_BITS) × DIV cycles, where P = 1 with parity enabled, else 0.
- Back-to-back frames: the next start bit begins on the cycle directly after the last stop-bit cycle.

## Configuration
- UART_TX_PARITY_EN defined: the PARITY state is compiled in. The parity bit is the XOR of all data bits, inverted when PARITY_ODD = 1, and is sent between the last data bit and the first stop bit.
- UART_TX_PARITY_EN undefined: no PARITY state and no parity logic. PARITY_ODD has no effect. Frames are N-format.

## Test plan
- Defaults, macro off, push 0x41 once. Start bit falls 1 cycle after accept. Line sequence 0,1,0,0,0,0,0,1,0,1, each bit 434 cycles, total 4340 cycles. tx_busy then drops and the line stays 1.
- Hold tx_valid high for 6 cycles with FIFO_DEPTH = 4. Exactly 5 words are accepted and tx_ready goes low on the 6th cycle. The 5 frames are sent with no idle gap and fifo_count returns to 0.
- Macro on, push 0x41 (two ones). PARITY_ODD = 0 gives parity bit 0; PARITY_ODD = 1 gives parity bit 1. Frame length is 11×434 cycles.
- DATA_BITS = 7, STOP_BITS = 2, push 0x7F. Line sequence 0, 1×7, 1×2; frame length 10×DIV cycles.
- Assert tx_rst_n low during the D3 bit with 2 words queued. tx_output = 1 immediately, fifo_count = 0, tx_ready = 1. After release, no frame starts until a new push.
- Push a word on the same edge the FSM pops while fifo_count = 2. fifo_count stays 2 and the output order matches the push order.
